// File: rtl/bus_memory_controller.sv
// Memory/IO decoder for the 8227 core bus: mirrored RAM window, wait-stated ROM reads
// and NUM_IO MMIO output registers.
//
// state | meaning
// IDLE  | no ROM read in flight; a ROM read stalls here for its first wait cycle
// WAIT  | ROM read stalled, counting the remaining wait cycles
// DONE  | ROM data presented with ready=1; always returns to IDLE
module bus_memory_controller #(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 16,
    parameter int                RAM_DEPTH = 64,
    parameter logic [ADDR_W-1:0] RAM_BASE  = 16'h0000,
    parameter int unsigned       RAM_SPAN  = 32'h0200,
    parameter logic [ADDR_W-1:0] ROM_BASE  = 16'h8000,
    parameter int                ROM_WAIT  = 1,
    parameter logic [ADDR_W-1:0] IO_BASE   = 16'h7F00,
    parameter int                NUM_IO    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        address,
    input  logic                     read_not_write,
    input  logic [DATA_W-1:0]        data_from_cpu,
    output logic [DATA_W-1:0]        data_to_cpu,
    output logic                     ready,
    input  logic [DATA_W-1:0]        rom_data,
    output logic [NUM_IO*DATA_W-1:0] io_out,
    output logic [NUM_IO-1:0]        io_strobe,
    output logic                     bus_error
);

    localparam int IDX_W = $clog2(RAM_DEPTH);
    localparam int IO_W  = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
    localparam logic [ADDR_W:0] SPAN_LIM = (ADDR_W+1)'(RAM_SPAN);
    localparam logic [ADDR_W:0] IO_LIM   = (ADDR_W+1)'(NUM_IO);
    // The stalled IDLE cycle is the first wait cycle, so WAIT covers ROM_WAIT-1 cycles.
    localparam logic [3:0] CNT_LOAD = (ROM_WAIT >= 2) ? 4'(ROM_WAIT - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {SEL_NONE, SEL_IO, SEL_RAM, SEL_ROM} sel_t;

    state_t             state, state_nxt;
    logic [3:0]         cnt, cnt_nxt;
    logic [ADDR_W-1:0]  held_addr, held_addr_nxt;
    sel_t               sel;
    logic [ADDR_W:0]    io_diff, ram_diff, rom_diff;
    logic [IDX_W-1:0]   ram_idx;
    logic [IO_W-1:0]    io_idx;
    logic               rom_rd, commit, err;
    logic [DATA_W-1:0]  ram [RAM_DEPTH];
    logic [DATA_W-1:0]  io_regs [NUM_IO];
    logic               unused_bits;

    // Borrow-extended differences give window membership without signed compares.
    assign io_diff  = {1'b0, address} - {1'b0, IO_BASE};
    assign ram_diff = {1'b0, address} - {1'b0, RAM_BASE};
    assign rom_diff = {1'b0, address} - {1'b0, ROM_BASE};
    assign ram_idx  = ram_diff[IDX_W-1:0];
    assign io_idx   = io_diff[IO_W-1:0];
    assign unused_bits = ^{ram_diff[ADDR_W:IDX_W], io_diff[ADDR_W:IO_W], rom_diff[ADDR_W-1:0]};

    always_comb begin
        sel = SEL_NONE;
        if (io_diff < IO_LIM)        sel = SEL_IO;
        else if (ram_diff < SPAN_LIM) sel = SEL_RAM;
        else if (!rom_diff[ADDR_W])  sel = SEL_ROM;
    end

    assign rom_rd = read_not_write && (sel == SEL_ROM);
    assign commit = !read_not_write && ready;
    assign err    = ready && ((sel == SEL_NONE) || (!read_not_write && sel == SEL_ROM));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            held_addr <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            held_addr <= held_addr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        held_addr_nxt = held_addr;
        case (state)
            IDLE: begin
                if (rom_rd && ROM_WAIT > 0) begin
                    held_addr_nxt = address;
                    cnt_nxt       = CNT_LOAD;
                    state_nxt     = (ROM_WAIT == 1) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (address != held_addr || !read_not_write) state_nxt = IDLE;
                else if (cnt == 4'd0)                        state_nxt = DONE;
                else                                         cnt_nxt   = cnt - 4'd1;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b1;
        case (state)
            IDLE:    if (rom_rd && ROM_WAIT > 0) ready = 1'b0;
            WAIT:    ready = 1'b0;
            default: ready = 1'b1;
        endcase
        if (reset) ready = 1'b1;
    end

    always_comb begin
        data_to_cpu = '0;
        if (read_not_write && ready) begin
            if (state == DONE) data_to_cpu = rom_data;
            else begin
                case (sel)
                    SEL_IO:  data_to_cpu = io_regs[io_idx];
                    SEL_RAM: data_to_cpu = ram[ram_idx];
                    SEL_ROM: data_to_cpu = rom_data;
                    default: data_to_cpu = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RAM_DEPTH; i++) ram[i] <= '0;
        end else if (commit && sel == SEL_RAM) begin
            ram[ram_idx] <= data_from_cpu;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_IO; i++) io_regs[i] <= '0;
            io_strobe <= '0;
            bus_error <= 1'b0;
        end else begin
            io_strobe <= '0;
            bus_error <= err;
            if (commit && sel == SEL_IO) begin
                io_regs[io_idx]   <= data_from_cpu;
                io_strobe[io_idx] <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_IO; g++) begin : g_io
        assign io_out[g*DATA_W +: DATA_W] = io_regs[g];
    end

endmodule
